keypad_scan: RTL and testbench

Scans a 4x4 active-low key matrix, debounces it, and reports the pressed key as 3-bit row/column coordinates. It is the producer side of the coordinate interface: the game controller compares these coordinates against the mole position.
- Exactly one key at a time is reported.
- When no key is pressed, the outputs hold an idle code that can never match a valid mole position.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_scan_tick_gen.sv | 27 ++
 rtl/keypad_scan.sv | 147 ++++++++++++++
 tb/tb_keypad_scan.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'b00,
        DEBOUNCE = 2'b01,
        PRESSED  = 2'b10,
        RELEASE  = 2'b11
    } state_t;

    localparam logic [2:0] IDLE_COORD = 3'd7;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Index of the lowest row that reads low (active-low sense); 0 if none.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        lowest_low = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = i[1:0];
        end
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running prescaler producing a one-clk tick every SCAN_DIV cycles.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix scanner with tick-based debounce, reporting the held
// key as row/col coordinates (7/7 when idle).
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] key_row_in,
    output logic [NUM_COLS-1:0] key_col_out,
    output logic [2:0]          row,
    output logic [2:0]          col,
    output logic                key_down,
    output logic                key_press
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT);

    logic                tick;
    logic [NUM_ROWS-1:0] sync1;
    logic [NUM_ROWS-1:0] sync2;
    state_t              state;
    state_t              state_next;
    logic [1:0]          cidx;
    logic [1:0]          cidx_next;
    logic [1:0]          ridx;
    logic [1:0]          ridx_next;
    logic [DW-1:0]       deb;
    logic [DW-1:0]       deb_next;
    logic [DW-1:0]       deb_inc;
    logic [2:0]          row_next;
    logic [2:0]          col_next;
    logic                down_next;
    logic                press_next;
    logic                row_high;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Row sense is asynchronous to clk; idle (all high) after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_row_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        deb_inc  = (deb == DEB_MAX) ? deb : deb + DW'(1);
        row_high = sync2[ridx];
    end

    always_comb begin
        state_next = state;
        cidx_next  = cidx;
        ridx_next  = ridx;
        deb_next   = deb;
        row_next   = row;
        col_next   = col;
        down_next  = key_down;
        press_next = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (sync2 != '1) begin
                        ridx_next  = lowest_low(sync2);
                        deb_next   = '0;
                        state_next = DEBOUNCE;
                    end else begin
                        cidx_next = cidx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_high) begin
                        deb_next = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            state_next = PRESSED;
                            row_next   = {1'b0, ridx};
                            col_next   = {1'b0, cidx};
                            down_next  = 1'b1;
                            press_next = 1'b1;
                        end
                    end else begin
                        state_next = SCAN;
                        cidx_next  = cidx + 2'd1;
                    end
                end
                PRESSED: begin
                    if (row_high) begin
                        deb_next   = '0;
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_high) begin
                        deb_next = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            row_next   = IDLE_COORD;
                            col_next   = IDLE_COORD;
                            down_next  = 1'b0;
                            cidx_next  = cidx + 2'd1;
                            state_next = SCAN;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    // Column drive is registered from the next column index so it stays glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            cidx        <= 2'd0;
            ridx        <= 2'd0;
            deb         <= '0;
            row         <= IDLE_COORD;
            col         <= IDLE_COORD;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_col_out <= 4'b1110;
        end else begin
            state       <= state_next;
            cidx        <= cidx_next;
            ridx        <= ridx_next;
            deb         <= deb_next;
            row         <= row_next;
            col         <= col_next;
            key_down    <= down_next;
            key_press   <= press_next;
            key_col_out <= ~(4'b0001 << cidx_next);
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a simulated key matrix and a
// tick-level behavioural model of scanning and debounce.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_row_in;
    logic [3:0]  key_col_out;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        key_down;
    logic        key_press;
    logic [15:0] keys = '0;

    int checks   = 0;
    int failures = 0;
    int presses  = 0;
    int cyc      = 0;

    // Behavioural model state
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    int         m_pre;
    int         m_col;
    int         m_cand;
    int         m_lows;
    int         m_highs;
    logic [3:0] e_cols;
    logic [2:0] e_row;
    logic [2:0] e_col;
    logic       e_down;
    logic       e_press;
    logic [12:0] obs;
    logic [12:0] want;

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low when its column is driven.
    always_comb begin
        key_row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !key_col_out[c]) key_row_in[r] = 1'b0;
            end
        end
    end

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_row_in  (key_row_in),
        .key_col_out (key_col_out),
        .row         (row),
        .col         (col),
        .key_down    (key_down),
        .key_press   (key_press)
    );

    task automatic model_reset();
        m_s1    = 4'hF;
        m_s2    = 4'hF;
        m_pre   = 0;
        m_col   = 0;
        m_cand  = -1;
        m_lows  = 0;
        m_highs = 0;
        e_cols  = 4'b1110;
        e_row   = 3'd7;
        e_col   = 3'd7;
        e_down  = 1'b0;
        e_press = 1'b0;
        cyc     = 0;
    endtask

    // One clock: press accepted after DEB_CNT further low ticks on the found row,
    // release accepted after DEB_CNT+1 consecutive high ticks on the held row.
    task automatic advance();
        logic [3:0] s_now;
        logic [3:0] s_old;
        bit         tk;
        #1;
        s_now = key_row_in;
        @(posedge clk);
        s_old = m_s2;
        m_s2  = m_s1;
        m_s1  = s_now;
        tk    = (m_pre == SCAN_DIV - 1);
        m_pre = (m_pre + 1) % SCAN_DIV;
        cyc++;
        e_press = 1'b0;
        if (tk) begin
            if (!e_down) begin
                if (m_cand < 0) begin
                    if (s_old != 4'hF) begin
                        for (int r = 3; r >= 0; r--) if (!s_old[r]) m_cand = r;
                        m_lows = 0;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end else if (!s_old[m_cand]) begin
                    m_lows++;
                    if (m_lows == DEB_CNT) begin
                        e_down  = 1'b1;
                        e_press = 1'b1;
                        e_row   = 3'(m_cand);
                        e_col   = 3'(m_col);
                        m_highs = 0;
                    end
                end else begin
                    m_cand = -1;
                    m_col  = (m_col + 1) % 4;
                end
            end else if (s_old[m_cand]) begin
                m_highs++;
                if (m_highs == DEB_CNT + 1) begin
                    e_down = 1'b0;
                    e_row  = 3'd7;
                    e_col  = 3'd7;
                    m_cand = -1;
                    m_col  = (m_col + 1) % 4;
                end
            end else begin
                m_highs = 0;
            end
        end
        e_cols = ~(4'b0001 << m_col);
        @(negedge clk);
        if (key_press === 1'b1) presses++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({key_col_out, row, col, key_down, key_press} !== 13'b1110_111_111_0_0) begin
            failures++;
            $display("[TB] FAIL reset_values got=%b want=%b", {key_col_out, row, col, key_down, key_press}, 13'b1110_111_111_0_0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 20; i++) begin
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL idle_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
            checks++;
            if (key_col_out !== ~(4'b0001 << ((i / 4) % 4))) begin
                failures++;
                $display("[TB] FAIL idle_col_step cyc=%0d got=%b want=%b", i, key_col_out, ~(4'b0001 << ((i / 4) % 4)));
            end
        end
    endtask

    task automatic test_hold_release();
        bit fell = 1'b0;
        do_reset();
        keys    = '0;
        keys[2*4+1] = 1'b1;
        presses = 0;
        for (int i = 0; i < 80; i++) begin
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL hold_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
        end
        checks++;
        if (presses !== 1) begin
            failures++;
            $display("[TB] FAIL hold_press_count got=%0d want=1", presses);
        end
        checks++;
        if ({key_col_out, row, col, key_down} !== 11'b1101_010_001_1) begin
            failures++;
            $display("[TB] FAIL hold_coords got=%b want=%b", {key_col_out, row, col, key_down}, 11'b1101_010_001_1);
        end
        keys = '0;
        for (int i = 0; i < 40; i++) begin
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL release_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
            if (!fell && key_down === 1'b0) begin
                fell = 1'b1;
                checks++;
                if ({key_col_out, row, col} !== 10'b1011_111_111) begin
                    failures++;
                    $display("[TB] FAIL release_resume got=%b want=%b", {key_col_out, row, col}, 10'b1011_111_111);
                end
            end
        end
        checks++;
        if (!fell) begin
            failures++;
            $display("[TB] FAIL release_timeout got=key_down_high want=key_down_low");
        end
    endtask

    task automatic test_bounce();
        int guard = 0;
        do_reset();
        keys    = '0;
        presses = 0;
        while (e_cols != 4'b0111 && guard < 40) begin
            advance();
            guard++;
        end
        keys[0*4+3] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 8) keys = '0;
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL bounce_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
        end
        checks++;
        if (presses !== 0 || row !== 3'd7 || col !== 3'd7) begin
            failures++;
            $display("[TB] FAIL bounce_no_press got=presses%0d/r%0d/c%0d want=presses0/r7/c7", presses, row, col);
        end
    endtask

    task automatic test_two_keys();
        do_reset();
        keys = '0;
        keys[1*4+0] = 1'b1;
        keys[3*4+0] = 1'b1;
        presses = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 80) keys = '0;
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL two_keys_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
            if (i == 79) begin
                checks++;
                if ({row, col, key_down} !== 7'b001_000_1 || presses !== 1) begin
                    failures++;
                    $display("[TB] FAIL two_keys_lowest got=r%0d/c%0d/d%b/p%0d want=r1/c0/d1/p1", row, col, key_down, presses);
                end
            end
        end
    endtask

    task automatic test_glitch_release();
        do_reset();
        keys = '0;
        keys[2*4+2] = 1'b1;
        for (int i = 0; i < 80; i++) advance();
        presses = 0;
        keys = '0;
        for (int i = 0; i < 34; i++) begin
            if (i == 4) keys[2*4+2] = 1'b1;
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL glitch_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
        end
        checks++;
        if (presses !== 0 || key_down !== 1'b1 || row !== 3'd2 || col !== 3'd2) begin
            failures++;
            $display("[TB] FAIL glitch_held got=p%0d/d%b/r%0d/c%0d want=p0/d1/r2/c2", presses, key_down, row, col);
        end
        keys = '0;
        for (int i = 0; i < 40; i++) advance();
        checks++;
        if ({row, col, key_down} !== 7'b111_111_0) begin
            failures++;
            $display("[TB] FAIL glitch_final_idle got=%b want=%b", {row, col, key_down}, 7'b111_111_0);
        end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        keys = '0;
        keys[1*4+0] = 1'b1;
        for (int i = 0; i < 8; i++) advance();
        rst = 1'b1;
        #1;
        checks++;
        if ({key_col_out, row, col, key_down, key_press} !== 13'b1110_111_111_0_0) begin
            failures++;
            $display("[TB] FAIL rst_mid_values got=%b want=%b", {key_col_out, row, col, key_down, key_press}, 13'b1110_111_111_0_0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        presses = 0;
        for (int i = 1; i <= 25; i++) begin
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL rst_mid_model cyc=%0d got=%b want=%b", cyc, obs, want);
            end
            if (i == 15 || i == 25) begin
                checks++;
                if (presses !== (i == 25 ? 1 : 0)) begin
                    failures++;
                    $display("[TB] FAIL rst_mid_press cyc=%0d got=%0d want=%0d", i, presses, (i == 25 ? 1 : 0));
                end
            end
        end
        keys = '0;
        for (int i = 0; i < 40; i++) advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            int nkeys;
            int hold;
            keys  = '0;
            nkeys = $urandom_range(0, 2);
            for (int k = 0; k < nkeys; k++) keys[$urandom_range(0, 15)] = 1'b1;
            hold = $urandom_range(1, 60);
            for (int i = 0; i < hold; i++) begin
                advance();
                obs  = {key_col_out, row, col, key_down, key_press};
                want = {e_cols, e_row, e_col, e_down, e_press};
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("[TB] FAIL random_model cyc=%0d got=%b want=%b", cyc, obs, want);
                end
            end
        end
        keys = '0;
        for (int i = 0; i < 60; i++) begin
            advance();
            obs  = {key_col_out, row, col, key_down, key_press};
            want = {e_cols, e_row, e_col, e_down, e_press};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("[TB] FAIL random_drain cyc=%0d got=%b want=%b", cyc, obs, want);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_release();
        test_bounce();
        test_two_keys();
        test_glitch_release();
        test_reset_mid_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
